// File: rtl/io_bus_arbiter_pkg.sv
// Shared I/O bus definitions: arbiter FSM encoding, idle address and peripheral map.
package io_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } bus_state_t;

    // Parked bus address; nothing on the peripheral map decodes it.
    localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'h0000_0000;

    localparam logic [31:0] LEDG_ADDR = 32'hF000_0008;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bundle of the two master request ports and the shared peripheral bus.
interface io_bus_arbiter_if;

    logic        m0_req;
    logic        m1_req;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m0_we;
    logic        m1_we;
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_done;
    logic        m1_done;
    logic [31:0] m_rdata;
    logic [31:0] abus;
    logic [31:0] dbus;
    logic        wren;
    logic [31:0] rdbus;

    // Arbiter side.
    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we, rdbus,
        output m0_gnt, m1_gnt, m0_done, m1_done, m_rdata, abus, dbus, wren
    );

    // Masters and peripherals side.
    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we, rdbus,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m_rdata, abus, dbus, wren
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (&req) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the shared I/O bus; every transfer is IDLE -> ADDR -> DATA.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    io_bus_arbiter_if.slave bus
);

    bus_state_t  state_reg;
    logic        last_reg;
    logic        id_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;

    logic [1:0]  req;
    logic        winner;
    logic        win_valid;
    logic        in_xfer;
    logic [1:0]  gnt_vec;
    logic [1:0]  done_vec;

    assign req = {bus.m1_req, bus.m0_req};

    rr_arb2 u_rr_arb2 (
        .req    (req),
        .last   (last_reg),
        .winner (winner),
        .valid  (win_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b1;
            id_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        id_reg    <= winner;
                        last_reg  <= winner;
                        addr_reg  <= winner ? bus.m1_addr  : bus.m0_addr;
                        wdata_reg <= winner ? bus.m1_wdata : bus.m0_wdata;
                        we_reg    <= winner ? bus.m1_we    : bus.m0_we;
                        state_reg <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (!we_reg) begin
                        rdata_reg <= bus.rdbus;
                    end
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_xfer = (state_reg != ST_IDLE);

    for (genvar gi = 0; gi < 2; gi++) begin : g_owner
        assign gnt_vec[gi]  = in_xfer && (id_reg == 1'(gi));
        assign done_vec[gi] = (state_reg == ST_DATA) && (id_reg == 1'(gi));
    end

    assign bus.m0_gnt  = gnt_vec[0];
    assign bus.m1_gnt  = gnt_vec[1];
    assign bus.m0_done = done_vec[0];
    assign bus.m1_done = done_vec[1];

    assign bus.abus = in_xfer ? addr_reg : IDLE_ADDR;
    assign bus.dbus = (state_reg == ST_ADDR) ? wdata_reg : '0;
    assign bus.wren = (state_reg == ST_ADDR) && we_reg;

    // Peripherals answer one cycle after the address, so read data is only
    // present on rdbus during DATA; pass it through there and hold it afterwards.
    assign bus.m_rdata = (state_reg == ST_DATA && !we_reg) ? bus.rdbus : rdata_reg;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed and randomized checks of io_bus_arbiter against a transfer-schedule model.
module tb_io_bus_arbiter;
    import io_bus_arbiter_pkg::*;

    localparam logic [31:0] UNMAPPED = 32'h1234_0000;

    typedef struct {
        logic        g0, g1, d0, d1, wren;
        logic [31:0] abus, dbus, rdata;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ledg;

    io_bus_arbiter_if bus();

    io_bus_arbiter #(.IDLE_ADDR(IDLE_ADDR_DEFAULT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // LEDG peripheral: registered write and registered read-back.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ledg      <= 8'h00;
            bus.rdbus <= 32'h0;
        end else begin
            if (bus.wren && bus.abus == LEDG_ADDR) ledg <= bus.dbus[7:0];
            bus.rdbus <= (bus.abus == LEDG_ADDR) ? {24'h0, ledg} : 32'h0;
        end
    end

    exp_t        q[$];
    exp_t        cur;
    bit          cur_idle;
    bit          last_m1;
    logic [31:0] last_rdata;
    logic [7:0]  model_ledg;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e.g0 = 1'b0; e.g1 = 1'b0; e.d0 = 1'b0; e.d1 = 1'b0; e.wren = 1'b0;
        e.abus = IDLE_ADDR_DEFAULT; e.dbus = 32'h0; e.rdata = last_rdata;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        $display("cycle t=%0t gnt=%b%b done=%b%b abus=%h dbus=%h wren=%b rdata=%h",
                 $time, bus.m1_gnt, bus.m0_gnt, bus.m1_done, bus.m0_done,
                 bus.abus, bus.dbus, bus.wren, bus.m_rdata);
        chk("m0_gnt",  32'(bus.m0_gnt),  32'(e.g0));
        chk("m1_gnt",  32'(bus.m1_gnt),  32'(e.g1));
        chk("m0_done", 32'(bus.m0_done), 32'(e.d0));
        chk("m1_done", 32'(bus.m1_done), 32'(e.d1));
        chk("wren",    32'(bus.wren),    32'(e.wren));
        chk("abus",    bus.abus,         e.abus);
        chk("dbus",    bus.dbus,         e.dbus);
        chk("m_rdata", bus.m_rdata,      e.rdata);
    endtask

    // When the bus is idle and someone asks, schedule the next two bus cycles.
    task automatic plan();
        exp_t        a, d;
        bit          w;
        logic [31:0] addr, wdata, rd;
        logic        we;
        if (!cur_idle || !(bus.m0_req || bus.m1_req)) return;
        if (bus.m0_req && bus.m1_req) w = !last_m1;
        else                          w = bus.m1_req;
        last_m1 = w;
        addr  = w ? bus.m1_addr  : bus.m0_addr;
        wdata = w ? bus.m1_wdata : bus.m0_wdata;
        we    = w ? bus.m1_we    : bus.m0_we;
        rd    = (addr == LEDG_ADDR) ? {24'h0, model_ledg} : 32'h0;
        a = idle_rec();
        a.g0 = !w; a.g1 = w; a.abus = addr; a.dbus = wdata; a.wren = we;
        d = a;
        d.d0 = !w; d.d1 = w; d.dbus = 32'h0; d.wren = 1'b0;
        if (!we) d.rdata = rd;
        q.push_back(a);
        q.push_back(d);
        if (we && addr == LEDG_ADDR) model_ledg = wdata[7:0];
        if (!we) last_rdata = rd;
    endtask

    task automatic cycle();
        plan();
        @(posedge clk);
        @(negedge clk);
        cur_idle = (q.size() == 0);
        if (cur_idle) cur = idle_rec();
        else          cur = q.pop_front();
        compare(cur);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        last_m1    = 1'b1;
        last_rdata = 32'h0;
        model_ledg = 8'h00;
        cur_idle   = 1'b1;
        cur        = idle_rec();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare(cur);
    endtask

    task automatic set_master(input int m, input logic r, input logic [31:0] a,
                              input logic [31:0] wd, input logic we);
        if (m == 0) begin
            bus.m0_req = r; bus.m0_addr = a; bus.m0_wdata = wd; bus.m0_we = we;
        end else begin
            bus.m1_req = r; bus.m1_addr = a; bus.m1_wdata = wd; bus.m1_we = we;
        end
    endtask

    task automatic set_req(input int m, input logic r);
        if (m == 0) bus.m0_req = r;
        else        bus.m1_req = r;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(2))
            0:       return LEDG_ADDR;
            1:       return UNMAPPED;
            default: return $urandom;
        endcase
    endfunction

    task automatic new_req(input int m);
        set_master(m, 1'b1, rand_addr(), $urandom, 1'($urandom_range(1)));
    endtask

    task automatic drive_master(input int m);
        logic r, own, dn;
        r   = (m == 0) ? bus.m0_req : bus.m1_req;
        own = (m == 0) ? cur.g0 : cur.g1;
        dn  = (m == 0) ? cur.d0 : cur.d1;
        if (r && dn) begin
            if ($urandom_range(3) == 0) new_req(m);
            else                        set_req(m, 1'b0);
        end else if (r && own) begin
            // The owner may wiggle its inputs or drop req; the transfer must not notice.
            if ($urandom_range(2) == 0) new_req(m);
            if ($urandom_range(7) == 0) set_req(m, 1'b0);
        end else if (!r && $urandom_range(2) == 0) begin
            new_req(m);
        end
    endtask

    initial begin
        int done_id[$];
        int done_cyc[$];

        set_master(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_master(1, 1'b0, 32'h0, 32'h0, 1'b0);
        do_reset();

        // m0 writes A5 to LEDG
        set_master(0, 1'b1, LEDG_ADDR, 32'h0000_00A5, 1'b1);
        cycle();
        chk("write_wren_addr", 32'(bus.wren), 32'h1);
        cycle();
        chk("write_done", 32'(bus.m0_done), 32'h1);
        set_req(0, 1'b0);
        cycle();
        chk("ledg_value", 32'(ledg), 32'h0000_00A5);

        // m1 reads it back
        set_master(1, 1'b1, LEDG_ADDR, 32'h0, 1'b0);
        cycle();
        cycle();
        chk("read_ledg", bus.m_rdata, 32'h0000_00A5);
        set_req(1, 1'b0);
        cycle();

        // unmapped read
        set_master(1, 1'b1, UNMAPPED, 32'h0, 1'b0);
        cycle();
        cycle();
        chk("read_unmapped", bus.m_rdata, 32'h0);
        set_req(1, 1'b0);
        cycle();

        // m0 changes its inputs during ADDR
        set_master(0, 1'b1, 32'h0000_1000, 32'h1111_1111, 1'b1);
        cycle();
        set_master(0, 1'b1, 32'hDEAD_0000, 32'h2222_2222, 1'b0);
        #1;
        chk("latched_abus", bus.abus, 32'h0000_1000);
        chk("latched_dbus", bus.dbus, 32'h1111_1111);
        cycle();
        set_req(0, 1'b0);
        cycle();

        // reset in ADDR of an m0 write
        set_master(0, 1'b1, LEDG_ADDR, 32'h0000_005A, 1'b1);
        cycle();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'h0);
        chk("rst_wren",   32'(bus.wren),   32'h0);
        chk("rst_abus",   bus.abus,        IDLE_ADDR_DEFAULT);
        chk("rst_dbus",   bus.dbus,        32'h0);
        set_master(0, 1'b1, LEDG_ADDR, 32'h0, 1'b0);
        set_master(1, 1'b1, UNMAPPED,  32'h0, 1'b0);
        do_reset();

        // both requests held from reset release
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (bus.m0_done) begin done_id.push_back(0); done_cyc.push_back(c); end
            if (bus.m1_done) begin done_id.push_back(1); done_cyc.push_back(c); end
        end
        chk("dual_done_count", 32'(done_id.size()), 32'd4);
        for (int i = 0; i < done_id.size(); i++) begin
            chk("dual_order", 32'(done_id[i]), 32'(i % 2));
            if (i > 0) chk("dual_gap", 32'(done_cyc[i] - done_cyc[i-1]), 32'd3);
        end
        chk("ledg_after_abort", 32'(ledg), 32'h0);
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        cycle();

        // randomized traffic with one reset in the middle
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            drive_master(0);
            drive_master(1);
            cycle();
        end
        chk("ledg_model", 32'(ledg), 32'(model_ledg));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
